clause_terminal_bank: RTL and testbench

- Multi-clause successor to the single-clause terminal cell at the right edge of the clause array.
- Snapshots status for NUM_CLAUSES clause rows, classifies each row as SAT / UNIT / CONFLICT / UNDEF, and serialises the results to the BCP controller over a valid/ready event port.
- A conflict takes priority over implications; the conflict event carries the max decision level.
- Also ORs the learned-clause (cclause) flags into a registered drive.

---
 rtl/sat_term_pkg.sv | 38 +++
 rtl/rr_pick_first.sv | 29 ++
 rtl/clause_terminal_bank.sv | 197 +++++++++++++++++++
 tb/tb_clause_terminal_bank.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sat_term_pkg.sv
// Shared definitions for the clause terminal bank and its helpers.
//   - Event kind encodings carried on the BCP event port.
//   - Saturating free-literal count encodings (3 behaves as MANY).
//   - FSM state enum and a per-row classification helper.
package sat_term_pkg;

    localparam logic [1:0] EVT_NONE     = 2'b00;
    localparam logic [1:0] EVT_IMP      = 2'b01;
    localparam logic [1:0] EVT_CONFLICT = 2'b10;

    localparam logic [1:0] FREECNT_ZERO = 2'd0;
    localparam logic [1:0] FREECNT_ONE  = 2'd1;
    localparam logic [1:0] FREECNT_MANY = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPT,
        ST_SCAN,
        ST_PRES,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        CLS_UNDEF,
        CLS_SAT,
        CLS_UNIT,
        CLS_CONFLICT
    } cls_t;

    // Row classification; a count of 3 falls through to UNDEF like MANY.
    function automatic cls_t classify(input logic sat, input logic [1:0] cnt);
        if (sat)                return CLS_SAT;
        if (cnt == FREECNT_ZERO) return CLS_CONFLICT;
        if (cnt == FREECNT_ONE)  return CLS_UNIT;
        return CLS_UNDEF;
    endfunction

endpackage

// File: rtl/rr_pick_first.sv
// Combinational round-robin picker: finds the first set bit of req at or
// after ptr, wrapping from N-1 back to 0.
//   req   in  N  candidate mask
//   ptr   in  W  starting position (must be < N)
//   found out 1  any bit of req set
//   idx   out W  index of the chosen bit (0 when !found)
module rr_pick_first #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Walk positions ptr, ptr+1, ... in priority order; first hit wins.
        for (int i = 0; i < N; i++) begin
            if (!found && req[(int'(ptr) + i) % N]) begin
                found = 1'b1;
                idx   = W'((int'(ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/clause_terminal_bank.sv
// Multi-row clause terminal: snapshots NUM_CLAUSES clause rows, classifies
// each as SAT / UNIT / CONFLICT / UNDEF and serialises the results to the
// BCP controller over a valid/ready event port. A conflict pre-empts all
// implications and reports the highest level among the conflicting rows.
//   clk, rst        clock, synchronous active-high reset
//   eval_i          start strobe, only taken in IDLE
//   clausesat_i     per-row satisfied flag
//   freelitcnt_i    per-row 2-bit saturating free-literal count
//   cclause_i       per-row learned-clause flag
//   max_lvl_i       per-row max assigned level
//   imp_drv_o       pending UNIT mask of the current snapshot
//   cclause_drv_o   registered OR of cclause_i
//   evt_*           event port (kind / row index / level)
//   busy_o, done_o  status; done_o pulses once per completed evaluation
module clause_terminal_bank
    import sat_term_pkg::*;
#(
    parameter int NUM_CLAUSES = 8,
    parameter int WIDTH_LVL   = 16,
    parameter int WIDTH_IDX   = $clog2(NUM_CLAUSES)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           eval_i,
    input  logic [NUM_CLAUSES-1:0]         clausesat_i,
    input  logic [2*NUM_CLAUSES-1:0]       freelitcnt_i,
    input  logic [NUM_CLAUSES-1:0]         cclause_i,
    input  logic [NUM_CLAUSES*WIDTH_LVL-1:0] max_lvl_i,
    output logic [NUM_CLAUSES-1:0]         imp_drv_o,
    output logic                           cclause_drv_o,
    output logic                           evt_valid_o,
    input  logic                           evt_ready_i,
    output logic [1:0]                     evt_kind_o,
    output logic [WIDTH_IDX-1:0]           evt_idx_o,
    output logic [WIDTH_LVL-1:0]           evt_lvl_o,
    output logic                           busy_o,
    output logic                           done_o
);

    state_t state;

    // Snapshot of the row inputs taken when an evaluation starts.
    logic [NUM_CLAUSES-1:0]           snap_sat;
    logic [2*NUM_CLAUSES-1:0]         snap_cnt;
    logic [NUM_CLAUSES*WIDTH_LVL-1:0] snap_lvl;

    logic [NUM_CLAUSES-1:0] unit_mask;
    logic [NUM_CLAUSES-1:0] conf_mask;
    logic [WIDTH_LVL-1:0]   conf_lvl;
    logic [WIDTH_IDX-1:0]   conf_idx;
    logic [WIDTH_IDX-1:0]   rr;

    // Classification of the snapshot plus conflict reduction.
    logic [NUM_CLAUSES-1:0] cls_unit;
    logic [NUM_CLAUSES-1:0] cls_conf;
    logic [WIDTH_LVL-1:0]   c_lvl;
    logic [WIDTH_IDX-1:0]   c_idx;
    logic                   c_found;

    always_comb begin
        cls_unit = '0;
        cls_conf = '0;
        c_lvl    = '0;
        c_idx    = '0;
        c_found  = 1'b0;
        for (int k = 0; k < NUM_CLAUSES; k++) begin
            if (classify(snap_sat[k], snap_cnt[2*k +: 2]) == CLS_UNIT)
                cls_unit[k] = 1'b1;
            if (classify(snap_sat[k], snap_cnt[2*k +: 2]) == CLS_CONFLICT) begin
                cls_conf[k] = 1'b1;
                // Index is the lowest conflicting row, level is the max
                // over all of them; the two are deliberately independent.
                if (!c_found) begin
                    c_found = 1'b1;
                    c_idx   = WIDTH_IDX'(k);
                end
                if (snap_lvl[k*WIDTH_LVL +: WIDTH_LVL] > c_lvl)
                    c_lvl = snap_lvl[k*WIDTH_LVL +: WIDTH_LVL];
            end
        end
    end

    logic                 pick_found;
    logic [WIDTH_IDX-1:0] pick_idx;

    rr_pick_first #(
        .N (NUM_CLAUSES),
        .W (WIDTH_IDX)
    ) u_pick (
        .req   (unit_mask),
        .ptr   (rr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Bookkeeping for an accepted implication.
    logic [NUM_CLAUSES-1:0] evt_onehot;
    logic [NUM_CLAUSES-1:0] unit_left;
    logic [WIDTH_IDX-1:0]   rr_next;

    assign evt_onehot = {{(NUM_CLAUSES-1){1'b0}}, 1'b1} << evt_idx_o;
    assign unit_left  = unit_mask & ~evt_onehot;
    assign rr_next    = (evt_idx_o == WIDTH_IDX'(NUM_CLAUSES - 1)) ? '0
                                                                   : evt_idx_o + 1'b1;

    assign imp_drv_o = unit_mask;
    assign busy_o    = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            snap_sat      <= '0;
            snap_cnt      <= '0;
            snap_lvl      <= '0;
            unit_mask     <= '0;
            conf_mask     <= '0;
            conf_lvl      <= '0;
            conf_idx      <= '0;
            rr            <= '0;
            cclause_drv_o <= 1'b0;
            evt_valid_o   <= 1'b0;
            evt_kind_o    <= EVT_NONE;
            evt_idx_o     <= '0;
            evt_lvl_o     <= '0;
            done_o        <= 1'b0;
        end else begin
            cclause_drv_o <= |cclause_i;
            done_o        <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (eval_i) begin
                        snap_sat <= clausesat_i;
                        snap_cnt <= freelitcnt_i;
                        snap_lvl <= max_lvl_i;
                        state    <= ST_CAPT;
                    end
                end
                ST_CAPT: begin
                    unit_mask <= cls_unit;
                    conf_mask <= cls_conf;
                    conf_lvl  <= c_lvl;
                    conf_idx  <= c_idx;
                    state     <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (|conf_mask) begin
                        evt_valid_o <= 1'b1;
                        evt_kind_o  <= EVT_CONFLICT;
                        evt_idx_o   <= conf_idx;
                        evt_lvl_o   <= conf_lvl;
                        state       <= ST_PRES;
                    end else if (pick_found) begin
                        evt_valid_o <= 1'b1;
                        evt_kind_o  <= EVT_IMP;
                        evt_idx_o   <= pick_idx;
                        evt_lvl_o   <= snap_lvl[int'(pick_idx)*WIDTH_LVL +: WIDTH_LVL];
                        state       <= ST_PRES;
                    end else begin
                        done_o <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_PRES: begin
                    // Event fields stay put until the controller accepts.
                    if (evt_ready_i) begin
                        evt_valid_o <= 1'b0;
                        evt_kind_o  <= EVT_NONE;
                        evt_idx_o   <= '0;
                        evt_lvl_o   <= '0;
                        if (evt_kind_o == EVT_CONFLICT) begin
                            // Implications are moot once a conflict is out.
                            unit_mask <= '0;
                            done_o    <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            unit_mask <= unit_left;
                            rr        <= rr_next;
                            if (|unit_left) begin
                                state <= ST_SCAN;
                            end else begin
                                done_o <= 1'b1;
                                state  <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    unit_mask <= '0;
                    conf_mask <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clause_terminal_bank.sv
// Scoreboard bench for clause_terminal_bank (N=8). Stimulus pushes the
// expected events/done markers; a negedge monitor pops on every handshake
// and every done_o pulse.
module tb_clause_terminal_bank;

    localparam int N  = 8;
    localparam int WL = 16;
    localparam int WI = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              eval_i;
    logic [N-1:0]      clausesat_i;
    logic [2*N-1:0]    freelitcnt_i;
    logic [N-1:0]      cclause_i;
    logic [N*WL-1:0]   max_lvl_i;
    logic [N-1:0]      imp_drv_o;
    logic              cclause_drv_o;
    logic              evt_valid_o;
    logic              evt_ready_i;
    logic [1:0]        evt_kind_o;
    logic [WI-1:0]     evt_idx_o;
    logic [WL-1:0]     evt_lvl_o;
    logic              busy_o;
    logic              done_o;

    clause_terminal_bank #(
        .NUM_CLAUSES (N),
        .WIDTH_LVL   (WL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .eval_i        (eval_i),
        .clausesat_i   (clausesat_i),
        .freelitcnt_i  (freelitcnt_i),
        .cclause_i     (cclause_i),
        .max_lvl_i     (max_lvl_i),
        .imp_drv_o     (imp_drv_o),
        .cclause_drv_o (cclause_drv_o),
        .evt_valid_o   (evt_valid_o),
        .evt_ready_i   (evt_ready_i),
        .evt_kind_o    (evt_kind_o),
        .evt_idx_o     (evt_idx_o),
        .evt_lvl_o     (evt_lvl_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_done;
        logic [1:0]  kind;
        logic [WI-1:0] idx;
        logic [WL-1:0] lvl;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   hs_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_evt(input logic [1:0] k, input int idx, input int lvl);
        exp_t e;
        e.is_done = 1'b0;
        e.kind    = k;
        e.idx     = WI'(idx);
        e.lvl     = WL'(lvl);
        sb.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1;
        e.kind    = 2'b00;
        e.idx     = '0;
        e.lvl     = '0;
        sb.push_back(e);
    endtask

    // Monitor: compares every accepted event and every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (evt_valid_o && evt_ready_i) begin
                hs_count++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected event: got kind %0h idx %0d", evt_kind_o, evt_idx_o);
                end else begin
                    mon_e = sb.pop_front();
                    // A done marker at the head forces a kind miscompare.
                    check("evt kind", evt_kind_o, mon_e.is_done ? 2'b11 : mon_e.kind);
                    check("evt idx", evt_idx_o, mon_e.idx);
                    check("evt lvl", evt_lvl_o, mon_e.lvl);
                end
            end
            if (done_o) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected done_o: got 1 expected 0");
                end else begin
                    mon_e = sb.pop_front();
                    check("done order", done_o, mon_e.is_done);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_eval();
        eval_i = 1'b1;
        tick();
        eval_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy_o && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({name, " idle"}, ok, 1'b1);
        sb.delete();
    endtask

    task automatic wait_valid(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (evt_valid_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({name, " valid seen"}, ok, 1'b1);
    endtask

    // Row programming helpers: default every row to satisfied / MANY.
    logic [N-1:0]    v_sat;
    logic [2*N-1:0]  v_cnt;
    logic [N*WL-1:0] v_lvl;

    task automatic rows_default();
        v_sat = '1;
        for (int k = 0; k < N; k++) begin
            v_cnt[2*k +: 2] = 2'd2;
            v_lvl[k*WL +: WL] = WL'(10 + k);
        end
    endtask

    task automatic set_row(input int k, input logic sat, input logic [1:0] cnt, input int lvl);
        v_sat[k] = sat;
        v_cnt[2*k +: 2] = cnt;
        v_lvl[k*WL +: WL] = WL'(lvl);
    endtask

    task automatic apply_rows();
        clausesat_i  = v_sat;
        freelitcnt_i = v_cnt;
        max_lvl_i    = v_lvl;
    endtask

    int hs0;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        eval_i       = 1'b0;
        evt_ready_i  = 1'b1;
        cclause_i    = '0;
        clausesat_i  = '0;
        freelitcnt_i = '0;
        max_lvl_i    = '0;
        tick();
        tick();
        check("reset valid", evt_valid_o, 1'b0);
        check("reset busy", busy_o, 1'b0);
        check("reset done", done_o, 1'b0);
        check("reset imp_drv", imp_drv_o, 8'h00);
        check("reset kind", evt_kind_o, 2'b00);
        rst = 1'b0;
        tick();

        // Two implications, rows 2 then 5; unsatisfied filler rows MANY.
        rows_default();
        v_sat = '0;
        set_row(2, 1'b0, 2'd1, 12);
        set_row(5, 1'b0, 2'd1, 15);
        apply_rows();
        push_evt(2'b01, 2, 12);
        push_evt(2'b01, 5, 15);
        push_done();
        pulse_eval();
        check("t1 valid at +1", evt_valid_o, 1'b0);
        tick();
        check("t1 imp_drv", imp_drv_o, 8'h24);
        check("t1 valid at +2", evt_valid_o, 1'b0);
        tick();
        check("t1 valid at +3", evt_valid_o, 1'b1);
        wait_idle("t1a");
        check("t1 imp_drv cleared", imp_drv_o, 8'h00);
        // rr now 6: wrap brings row 2 first again.
        push_evt(2'b01, 2, 12);
        push_evt(2'b01, 5, 15);
        push_done();
        pulse_eval();
        wait_idle("t1b");

        // Conflict on rows 3 (lvl 7) and 6 (lvl 9) pre-empts UNIT row 1.
        rows_default();
        set_row(1, 1'b0, 2'd1, 4);
        set_row(3, 1'b0, 2'd0, 7);
        set_row(6, 1'b0, 2'd0, 9);
        set_row(7, 1'b0, 2'd3, 40);
        apply_rows();
        push_evt(2'b10, 3, 9);
        push_done();
        pulse_eval();
        wait_idle("t2");

        // All satisfied: done_o only, three cycles after eval.
        rows_default();
        apply_rows();
        push_done();
        pulse_eval();
        check("t3 done at +1", done_o, 1'b0);
        tick();
        check("t3 done at +2", done_o, 1'b0);
        tick();
        check("t3 done at +3", done_o, 1'b1);
        check("t3 no valid", evt_valid_o, 1'b0);
        wait_idle("t3");

        // Backpressure on implication at row 4 (rr is 6 here).
        rows_default();
        set_row(4, 1'b0, 2'd1, 16'h1234);
        apply_rows();
        evt_ready_i = 1'b0;
        push_evt(2'b01, 4, 16'h1234);
        push_done();
        pulse_eval();
        wait_valid("t4");
        for (int c = 0; c < 5; c++) begin
            check("t4 hold valid", evt_valid_o, 1'b1);
            check("t4 hold kind", evt_kind_o, 2'b01);
            check("t4 hold idx", evt_idx_o, 3'd4);
            check("t4 hold lvl", evt_lvl_o, 16'h1234);
            tick();
        end
        hs0 = hs_count;
        evt_ready_i = 1'b1;
        wait_idle("t4");
        check("t4 handshakes", hs_count - hs0, 1);

        // Reset while presenting: everything drops, no done pulse.
        rows_default();
        set_row(0, 1'b0, 2'd1, 3);
        apply_rows();
        evt_ready_i = 1'b0;
        pulse_eval();
        wait_valid("t5");
        rst = 1'b1;
        tick();
        check("t5 valid after rst", evt_valid_o, 1'b0);
        check("t5 busy after rst", busy_o, 1'b0);
        check("t5 done after rst", done_o, 1'b0);
        check("t5 imp_drv after rst", imp_drv_o, 8'h00);
        check("t5 idx after rst", evt_idx_o, 3'd0);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("t5 no done", done_o, 1'b0);
        end
        // rr was cleared, so row 2 precedes row 5.
        evt_ready_i = 1'b1;
        rows_default();
        set_row(2, 1'b0, 2'd1, 22);
        set_row(5, 1'b0, 2'd1, 25);
        apply_rows();
        push_evt(2'b01, 2, 22);
        push_evt(2'b01, 5, 25);
        push_done();
        pulse_eval();
        wait_idle("t5b");

        // Learned-clause drive follows the input by one cycle.
        check("t6 cclause idle", cclause_drv_o, 1'b0);
        cclause_i = 8'b0001_0000;
        tick();
        cclause_i = '0;
        check("t6 cclause high", cclause_drv_o, 1'b1);
        tick();
        check("t6 cclause low", cclause_drv_o, 1'b0);

        // eval_i while busy must not disturb the running evaluation.
        rows_default();
        set_row(2, 1'b0, 2'd1, 16'h55);
        apply_rows();
        push_evt(2'b01, 2, 16'h55);
        push_done();
        pulse_eval();
        v_sat = '0;
        v_cnt = '0;
        apply_rows();
        eval_i = 1'b1;
        check("t6 busy", busy_o, 1'b1);
        tick();
        tick();
        eval_i = 1'b0;
        wait_idle("t6");
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t6 stays idle", busy_o, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
